decode_queue: RTL
=================

# decode_queue

Parametrised instruction queue with integrated field decode, placed between the fetch stage and the control/decode stage of the pipelined MIPS core. It buffers up to DEPTH fetched instructions and their PCs behind a valid/ready handshake. It presents the head entry already split into opcode, register, shamt, funct and immediate fields, plus an extended 32-bit immediate and a jump target. It replaces the purely combinational field splitter and absorbs fetch/decode rate mismatch, stalls and flushes.

## Interface
- DEPTH, 4: number of queue entries; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count.

- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept; equals (count != DEPTH).
- in_instr  input  32  instruction word.
- in_pc  input  32  address of in_instr.
- flush  input  1  synchronous discard of all entries (branch/jump redirect).
- out_valid  output  1  head entry valid; equals (count != 0).
- out_ready  input  1  decode stage consumes head.
- opcode, funct  output  6  Instr[31:26], Instr[5:0] of head.
- rs, rt, rd, shamt  output  5  Instr[25:21], [20:16], [15:11], [10:6] of head.
- imm16  output  16  Instr[15:0] of head.
- imm26  output  26  Instr[25:0] of head.
- ext_imm  output  32  mode-extended immediate (see Operation).
- jump_target  output  32  {head_pc+4 [31:28], imm26, 2'b00}.
- out_pc  output  32  PC of head.
- count  output  CNT_W  current occupancy, 0..DEPTH.

## Operation
- Circular buffer: wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap DEPTH-1 → 0), count register.
- Push when in_valid && in_ready: store {in_instr, in_pc} at wr_ptr, wr_ptr+1.
- Pop when out_valid && out_ready: rd_ptr+1.
- Push and pop in the same cycle leave count unchanged. When full, in_ready=0, so no push, even when a pop occurs that cycle. There is no pass-through path.
- flush=1: next edge sets wr_ptr=rd_ptr=0 and count=0. Any push or pop in that cycle is discarded. Flush has priority over push and pop.
- Decode outputs are combinational from the storage entry at rd_ptr. When out_valid=0, all field outputs, ext_imm, jump_target and out_pc are forced to 0.
- ext_imm mode by head opcode:
  - 0x0C andi, 0x0D ori, 0x0E xori: zero-extend imm16.
  - 0x0F lui: {imm16, 16'h0}.
  - All other opcodes: sign-extend imm16.
- Reset: pointers, count and all storage cleared to 0. in_ready=1, out_valid=0, every decode output 0. Reset mid-operation discards all entries immediately, asynchronously.

## Timing
- Push-to-visible latency is 1 cycle. An entry written at edge N drives out_valid=1 and its fields from edge N onward, when it is the head.
- Pop takes effect at the edge. The next head's fields appear in the same cycle as the edge.
- in_ready and out_valid depend only on registered count, not on in_valid or out_ready. There are no combinational in→out handshake paths.
- After a flush edge: out_valid=0 and in_ready=1. The first post-flush push is visible 1 cycle later.
- Back-to-back operation: sustains one push and one pop per cycle when 0 < count < DEPTH.

## Test plan
- Reset then push 0x3C01_1234 (lui) @pc 0x0000_3000, out_ready=0 → next cycle out_valid=1, opcode=0x0F, rt=1, ext_imm=0x1234_0000, count=1.
- Push 0x3422_FFFF (ori) then 0x2003_FFFF (addi), pop both → first gives ext_imm=0x0000_FFFF, second gives ext_imm=0xFFFF_FFFF, out_valid then 0.
- Fill DEPTH=4 with out_ready=0 → in_ready=0 at count=4. Hold in_valid with a 5th word → not stored. Pop one → in_ready=1 next cycle; FIFO order is preserved across pointer wrap.
- Push j 0x0800_0C00 @pc 0x0000_3004 → jump_target=0x0000_3000, rs/rt/rd fields match Instr slices.
- count=3, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, all outputs 0, pushed word not present.
- Assert reset asynchronously mid-stream with count=2 → outputs cleared before the next clk edge. After release, queue empty and in_ready=1.

Source files
------------

// File: rtl/decode_queue_if.sv
// Handshake and decoded-field bundle between fetch, decode_queue and the decode stage.
// The queue itself connects through the slave modport; the fetch/decode side connects through the master modport.
interface decode_queue_if #(
   parameter int CNT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [31:0]      in_pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [5:0]       opcode;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic [4:0]       shamt;
   logic [5:0]       funct;
   logic [15:0]      imm16;
   logic [25:0]      imm26;
   logic [31:0]      ext_imm;
   logic [31:0]      jump_target;
   logic [31:0]      out_pc;
   logic [CNT_W-1:0] count;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
             imm16, imm26, ext_imm, jump_target, out_pc, count
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
             imm16, imm26, ext_imm, jump_target, out_pc, count
   );
endinterface

// File: rtl/decode_queue.sv
// Instruction queue between fetch and decode. It buffers {instr, pc} pairs and
// presents the head entry already split into MIPS fields, with the extended immediate and the jump target.
module decode_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   decode_queue_if.slave q
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      instr_q [DEPTH];
   logic [31:0]      instr_d [DEPTH];
   logic [31:0]      pc_q    [DEPTH];
   logic [31:0]      pc_d    [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push;
   logic             pop;
   logic [31:0]      head_instr;
   logic [31:0]      head_pc;
   logic [3:0]       pc4_hi;

   // Handshakes depend only on the registered count, so no input reaches these outputs combinationally.
   assign q.in_ready  = (count_q != CNT_W'(DEPTH));
   assign q.out_valid = (count_q != '0);
   assign q.count     = count_q;
   assign push        = q.in_valid && q.in_ready;
   assign pop         = q.out_valid && q.out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      instr_d  = instr_q;
      pc_d     = pc_q;
      if (q.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            instr_d[wr_ptr_q] = q.in_instr;
            pc_d[wr_ptr_q]    = q.in_pc;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         instr_q  <= instr_d;
         pc_q     <= pc_d;
      end
   end

   assign head_instr = instr_q[rd_ptr_q];
   assign head_pc    = pc_q[rd_ptr_q];
   // Upper nibble of head_pc+4: a carry into bit 28 occurs only when bits [27:2] are all ones.
   assign pc4_hi     = head_pc[31:28] + {3'b000, &head_pc[27:2]};

   always_comb begin
      q.opcode      = '0;
      q.rs          = '0;
      q.rt          = '0;
      q.rd          = '0;
      q.shamt       = '0;
      q.funct       = '0;
      q.imm16       = '0;
      q.imm26       = '0;
      q.ext_imm     = '0;
      q.jump_target = '0;
      q.out_pc      = '0;
      if (q.out_valid) begin
         q.opcode      = head_instr[31:26];
         q.rs          = head_instr[25:21];
         q.rt          = head_instr[20:16];
         q.rd          = head_instr[15:11];
         q.shamt       = head_instr[10:6];
         q.funct       = head_instr[5:0];
         q.imm16       = head_instr[15:0];
         q.imm26       = head_instr[25:0];
         q.out_pc      = head_pc;
         q.jump_target = {pc4_hi, head_instr[25:0], 2'b00};
         case (head_instr[31:26])
            6'h0C, 6'h0D, 6'h0E: q.ext_imm = {16'h0000, head_instr[15:0]};
            6'h0F:               q.ext_imm = {head_instr[15:0], 16'h0000};
            default:             q.ext_imm = {{16{head_instr[15]}}, head_instr[15:0]};
         endcase
      end
   end
endmodule
